// File: rtl/vend_if.sv
// Handshake bundle between the vending controller and its panel/dispenser.
// The controller takes the slave view; the panel/dispenser side takes the master view.
interface vend_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CNT_W     = 8
);
  logic                 token_in;
  logic [NUM_ITEMS-1:0] item_req;
  logic                 cancel;
  logic                 dispense_done;

  logic                 vend_busy;
  logic                 dispense;
  logic [3:0]           item_select;
  logic [CNT_W-1:0]     credit;
  logic [CNT_W-1:0]     change_tokens;
  logic                 change_valid;
  logic                 deny;
  logic                 token_reject;
  logic                 fault;

  modport master (
    output token_in, item_req, cancel, dispense_done,
    input  vend_busy, dispense, item_select, credit, change_tokens,
           change_valid, deny, token_reject, fault
  );

  modport slave (
    input  token_in, item_req, cancel, dispense_done,
    output vend_busy, dispense, item_select, credit, change_tokens,
           change_valid, deny, token_reject, fault
  );
endinterface

// File: rtl/vend_multi.sv
// Multi-product token vending controller: credit accumulation, priced vend with
// dispense timeout, and single-cycle change return. All outputs are registered.
module vend_multi #(
  parameter int                         NUM_ITEMS    = 4,
  parameter int                         CNT_W        = 8,
  parameter logic [NUM_ITEMS*CNT_W-1:0] PRICES       = {8'd4, 8'd3, 8'd2, 8'd1},
  parameter int                         MAX_CREDIT   = 255,
  parameter int                         DISP_TIMEOUT = 1000
) (
  input logic   clk,
  input logic   reset,
  vend_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CREDIT);
  localparam int               TMR_W    = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;
  localparam bit               TMR_EN   = (DISP_TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_EN ? TMR_W'(DISP_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] credit_r, credit_nxt;
  logic [CNT_W-1:0] chg_tok_r, chg_tok_nxt;
  logic [CNT_W-1:0] price_r, price_nxt;
  logic [3:0]       sel_r, sel_nxt;
  logic [TMR_W-1:0] tmr_r, tmr_nxt;
  logic             disp_r, disp_nxt;
  logic             busy_r, busy_nxt;
  logic             chg_vld_r, chg_vld_nxt;
  logic             deny_r, deny_nxt;
  logic             rej_r, rej_nxt;
  logic             fault_r, fault_nxt;

  logic             req_hit;
  logic [3:0]       req_idx;
  logic [CNT_W-1:0] req_price;

  // Refund of a timed-out vend must not push credit past the ceiling.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, MAX_C}) return MAX_C;
    return sum[CNT_W-1:0];
  endfunction

  // Lowest set request bit wins; its price is picked alongside.
  always_comb begin
    req_hit   = 1'b0;
    req_idx   = '0;
    req_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.item_req[i] && !req_hit) begin
        req_hit   = 1'b1;
        req_idx   = 4'(i);
        req_price = PRICES[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_nxt   = state_r;
    credit_nxt  = credit_r;
    chg_tok_nxt = chg_tok_r;
    price_nxt   = price_r;
    sel_nxt     = sel_r;
    tmr_nxt     = tmr_r;
    disp_nxt    = disp_r;
    chg_vld_nxt = 1'b0;
    deny_nxt    = 1'b0;
    rej_nxt     = 1'b0;
    fault_nxt   = 1'b0;

    unique case (state_r)
      IDLE, CREDIT: begin
        if (bus.token_in) begin
          state_nxt = CREDIT;
          if (credit_r >= MAX_C) rej_nxt    = 1'b1;
          else                   credit_nxt = credit_r + 1'b1;
        end else if (bus.cancel) begin
          if (state_r == CREDIT) state_nxt = CHANGE;
        end else if (req_hit) begin
          if (credit_r >= req_price) begin
            credit_nxt = credit_r - req_price;
            price_nxt  = req_price;
            sel_nxt    = req_idx + 4'd1;
            disp_nxt   = 1'b1;
            tmr_nxt    = '0;
            state_nxt  = DISPENSE;
          end else begin
            deny_nxt = 1'b1;
          end
        end
      end

      DISPENSE: begin
        rej_nxt = bus.token_in;
        if (bus.dispense_done) begin
          disp_nxt  = 1'b0;
          sel_nxt   = '0;
          state_nxt = CHANGE;
        end else if (TMR_EN && (tmr_r == TMR_LAST)) begin
          fault_nxt  = 1'b1;
          disp_nxt   = 1'b0;
          sel_nxt    = '0;
          credit_nxt = sat_add(credit_r, price_r);
          state_nxt  = CHANGE;
        end else if (TMR_EN) begin
          tmr_nxt = tmr_r + 1'b1;
        end
      end

      CHANGE: begin
        rej_nxt     = bus.token_in;
        chg_vld_nxt = 1'b1;
        chg_tok_nxt = credit_r;
        credit_nxt  = '0;
        state_nxt   = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == DISPENSE) || (state_nxt == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      credit_r  <= '0;
      chg_tok_r <= '0;
      price_r   <= '0;
      sel_r     <= '0;
      tmr_r     <= '0;
      disp_r    <= 1'b0;
      busy_r    <= 1'b0;
      chg_vld_r <= 1'b0;
      deny_r    <= 1'b0;
      rej_r     <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      credit_r  <= credit_nxt;
      chg_tok_r <= chg_tok_nxt;
      price_r   <= price_nxt;
      sel_r     <= sel_nxt;
      tmr_r     <= tmr_nxt;
      disp_r    <= disp_nxt;
      busy_r    <= busy_nxt;
      chg_vld_r <= chg_vld_nxt;
      deny_r    <= deny_nxt;
      rej_r     <= rej_nxt;
      fault_r   <= fault_nxt;
    end
  end

  assign bus.vend_busy     = busy_r;
  assign bus.dispense      = disp_r;
  assign bus.item_select   = sel_r;
  assign bus.credit        = credit_r;
  assign bus.change_tokens = chg_tok_r;
  assign bus.change_valid  = chg_vld_r;
  assign bus.deny          = deny_r;
  assign bus.token_reject  = rej_r;
  assign bus.fault         = fault_r;

endmodule

// File: tb/tb_vend_multi.sv
// Scoreboard bench for vend_multi: a behavioural model predicts every cycle's
// outputs and each change payout; a monitor compares them against the DUT.
module tb_vend_multi;
  localparam int NI   = 4;
  localparam int CW   = 8;
  localparam int MAXC = 3;
  localparam int TMO  = 10;
  localparam logic [NI*CW-1:0] PR = {8'd4, 8'd3, 8'd2, 8'd1};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vend_if #(.NUM_ITEMS(NI), .CNT_W(CW)) vif ();

  vend_multi #(
    .NUM_ITEMS(NI), .CNT_W(CW), .PRICES(PR),
    .MAX_CREDIT(MAXC), .DISP_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (vif)
  );

  typedef struct packed {
    logic          busy;
    logic          disp;
    logic [3:0]    sel;
    logic [CW-1:0] cred;
    logic [CW-1:0] chg;
    logic          cv;
    logic          deny;
    logic          rej;
    logic          fault;
  } obs_t;

  obs_t exp_q[$];
  int   chg_q[$];
  int   total = 0;
  int   bad   = 0;
  int   price_tab[NI] = '{1, 2, 3, 4};

  // Reference model: plain counters and flags describing the machine's behaviour.
  int m_credit = 0, m_item = 0, m_paid = 0, m_elapsed = 0, m_chg = 0;
  bit m_vend = 0, m_refund = 0;

  task automatic step(input bit tok, input logic [NI-1:0] req, input bit can,
                      input bit done, input bit rst);
    obs_t e;
    int   idx;
    @(negedge clk);
    vif.token_in      = tok;
    vif.item_req      = req;
    vif.cancel        = can;
    vif.dispense_done = done;
    reset             = rst;
    e = '0;
    if (rst) begin
      m_credit = 0; m_item = 0; m_paid = 0; m_elapsed = 0; m_chg = 0;
      m_vend = 0; m_refund = 0;
    end else if (m_refund) begin
      e.cv = 1'b1; e.rej = tok;
      m_chg = m_credit; m_credit = 0; m_refund = 0;
      chg_q.push_back(m_chg);
    end else if (m_vend) begin
      e.rej = tok;
      if (done) begin
        m_vend = 0; m_item = 0; m_refund = 1;
      end else begin
        m_elapsed++;
        if (m_elapsed == TMO) begin
          e.fault = 1'b1; m_vend = 0; m_item = 0; m_refund = 1;
          m_credit = (m_credit + m_paid > MAXC) ? MAXC : m_credit + m_paid;
        end
      end
    end else if (tok) begin
      if (m_credit == MAXC) e.rej = 1'b1;
      else                  m_credit++;
    end else if (can) begin
      if (m_credit > 0) m_refund = 1;
    end else if (req != '0) begin
      idx = 0;
      while (!req[idx]) idx++;
      if (m_credit >= price_tab[idx]) begin
        m_credit -= price_tab[idx]; m_paid = price_tab[idx];
        m_item = idx + 1; m_vend = 1; m_elapsed = 0;
      end else begin
        e.deny = 1'b1;
      end
    end
    e.busy = m_vend || m_refund;
    e.disp = m_vend;
    e.sel  = 4'(m_item);
    e.cred = CW'(m_credit);
    e.chg  = CW'(m_chg);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tokens(input int n);
    for (int k = 0; k < n; k++) step(1'b1, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares each cycle's outputs and each change payout.
  initial begin
    obs_t e, a;
    int   c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {vif.vend_busy, vif.dispense, vif.item_select, vif.credit,
             vif.change_tokens, vif.change_valid, vif.deny, vif.token_reject, vif.fault};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got=%h want=%h (busy,disp,sel,cred,chg,cv,deny,rej,fault)",
                   $time, a, e);
        end
        if (a.cv === 1'b1) begin
          total++;
          if (chg_q.size() == 0) begin
            bad++;
            $display("FAIL change_extra t=%0t got change_tokens=%0d want no change strobe",
                     $time, a.chg);
          end else begin
            c = chg_q.pop_front();
            if (int'(a.chg) != c) begin
              bad++;
              $display("FAIL change_tokens t=%0t got=%0d want=%0d", $time, a.chg, c);
            end
          end
        end
      end
    end
  end

  initial begin
    bit tok, can, done, rst;
    logic [NI-1:0] req;
    vif.token_in = 1'b0; vif.item_req = '0; vif.cancel = 1'b0; vif.dispense_done = 1'b0;

    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b0001, 1'b1, 1'b1, 1'b1);
    idle(2);

    // 3 tokens, buy item 1 (price 2), completion, change of 1
    tokens(3);
    step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, '0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // insufficient credit then cancel
    tokens(1);
    step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // cancel in IDLE ignored, done outside DISPENSE ignored
    step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // token and request together, then request alone
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // saturation at MAX_CREDIT
    tokens(4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // dispense timeout with refund
    tokens(3);
    step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    idle(TMO + 3);

    // multiple buttons, tokens during vend
    tokens(2);
    step(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    tokens(2);
    step(1'b1, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // reset mid-dispense
    tokens(1);
    step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      tok  = ($urandom_range(0, 99) < 30);
      req  = ($urandom_range(0, 99) < 40) ? NI'($urandom) : '0;
      can  = ($urandom_range(0, 99) < 6);
      done = ($urandom_range(0, 99) < 12);
      rst  = ($urandom_range(0, 999) < 8);
      step(tok, req, can, done, rst);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || chg_q.size() != 0) begin
      bad++;
      $display("FAIL drain got exp_left=%0d chg_left=%0d want 0 and 0",
               exp_q.size(), chg_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
